// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared definitions for the sprite draw scheduler: field widths and FSM state encoding.
package sprite_draw_scheduler_pkg;

  localparam int X_W        = 10;
  localparam int Y_W        = 10;
  localparam int PIX_ADDR_W = 10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_RELEASE    = 3'd4
  } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping N-1 -> 0.
module sprite_draw_scheduler_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // cand[k] is the requester index sitting k places after the pointer
  logic [IDX_W-1:0] cand [N];

  for (genvar k = 0; k < N; k++) begin : g_cand
    assign cand[k] = IDX_W'((int'(ptr) + k) % N);
  end

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[cand[k]]) begin
        any     = 1'b1;
        gnt_idx = cand[k];
      end
    end
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Shares one draw_sprite unit between N_REQ requesters; round-robin grant, latched launch, watchdog abort.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int SID_W   = 2,
  parameter int TIMEOUT = 2047
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [N_REQ-1:0]            req,
  input  logic [X_W*N_REQ-1:0]        x_pos_flat,
  input  logic [Y_W*N_REQ-1:0]        y_pos_flat,
  input  logic [SID_W*N_REQ-1:0]      sid_flat,
  input  logic                        draw_done,
  input  logic [PIX_ADDR_W-1:0]       pix_addr,
  output logic                        draw_plot,
  output logic [X_W-1:0]              draw_x,
  output logic [Y_W-1:0]              draw_y,
  output logic [SID_W+PIX_ADDR_W-1:0] rom_addr,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic                        err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   rr_ptr, idx_q, gnt_idx;
  logic [N_REQ-1:0]   gnt, gnt_q;
  logic               gnt_any, grant, in_wait, wd_expired;
  logic [SID_W-1:0]   sid_q;
  logic [WD_W-1:0]    wd_cnt;

  sprite_draw_scheduler_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // draw_done low in IDLE means the unit is still finishing something: hold off
  assign grant      = (state == S_IDLE) && enable && gnt_any && draw_done;
  assign in_wait    = (state == S_WAIT_START) || (state == S_WAIT_DONE);
  assign wd_expired = in_wait && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign rom_addr   = {sid_q, pix_addr};

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:       if (grant) state_nx = S_LAUNCH;
      S_LAUNCH:     state_nx = S_WAIT_START;
      S_WAIT_START: if (wd_expired) state_nx = S_RELEASE;
                    else if (!draw_done) state_nx = S_WAIT_DONE;
      S_WAIT_DONE:  if (wd_expired || draw_done) state_nx = S_RELEASE;
      S_RELEASE:    state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    draw_plot = 1'b0;
    busy      = 1'b1;
    done      = '0;
    unique case (state)
      S_IDLE:    busy      = 1'b0;
      S_LAUNCH:  draw_plot = 1'b1;
      S_RELEASE: done      = gnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rr_ptr <= '0;
      idx_q  <= '0;
      gnt_q  <= '0;
      draw_x <= '0;
      draw_y <= '0;
      sid_q  <= '0;
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      // capture on the grant edge so later input changes cannot disturb the draw
      if (grant) begin
        idx_q  <= gnt_idx;
        gnt_q  <= gnt;
        draw_x <= x_pos_flat[X_W*int'(gnt_idx) +: X_W];
        draw_y <= y_pos_flat[Y_W*int'(gnt_idx) +: Y_W];
        sid_q  <= sid_flat[SID_W*int'(gnt_idx) +: SID_W];
      end
      if (state == S_LAUNCH) wd_cnt <= '0;
      else if (in_wait)      wd_cnt <= wd_cnt + 1'b1;
      if (wd_expired) err <= 1'b1;
      if (state == S_RELEASE)
        rr_ptr <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Randomized scoreboard bench: a queue-based round-robin model predicts grant order and latched data.
module tb_sprite_draw_scheduler;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int TMO  = 2047;
  localparam int MAXK = 3;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [N-1:0]      req;
  logic [10*N-1:0]   x_pos_flat, y_pos_flat;
  logic [SW*N-1:0]   sid_flat;
  logic              draw_done;
  logic [9:0]        pix_addr;
  logic              draw_plot, busy, err;
  logic [9:0]        draw_x, draw_y;
  logic [SW+9:0]     rom_addr;
  logic [N-1:0]      done;

  sprite_draw_scheduler #(.N_REQ(N), .SID_W(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .req(req),
    .x_pos_flat(x_pos_flat), .y_pos_flat(y_pos_flat), .sid_flat(sid_flat),
    .draw_done(draw_done), .pix_addr(pix_addr), .draw_plot(draw_plot),
    .draw_x(draw_x), .draw_y(draw_y), .rom_addr(rom_addr), .done(done),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; int x; int y; int sid; bit tmo; } exp_t;

  exp_t exp_q[$];
  int   n_pass, n_chk, n_exp, n_done, batch_id, rr_m;
  int   tot[N];
  int   px[N][MAXK], py[N][MAXK], ps[N][MAXK];
  int   served[N];
  bit   stuck;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic apply_pos(input int i, input int k);
    x_pos_flat[10*i +: 10] = 10'(px[i][k]);
    y_pos_flat[10*i +: 10] = 10'(py[i][k]);
    sid_flat[SW*i +: SW]   = SW'(ps[i][k]);
  endtask

  task automatic rand_pos();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAXK; k++) begin
        px[i][k] = $urandom_range(0, 1023);
        py[i][k] = $urandom_range(0, 1023);
        ps[i][k] = $urandom_range(0, (1 << SW) - 1);
      end
  endtask

  task automatic rand_batch();
    int sum;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      tot[i] = $urandom_range(0, 2);
      sum += tot[i];
    end
    if (sum == 0) tot[$urandom_range(0, N-1)] = 1;
    rand_pos();
  endtask

  // Model: every requester with draws left is pending; serve first pending at/after pointer.
  task automatic run_batch(input bit tmo_first);
    int   rem[N];
    int   k[N];
    int   p;
    bit   first;
    exp_t e;
    first = tmo_first;
    for (int i = 0; i < N; i++) begin
      rem[i] = tot[i];
      k[i]   = 0;
    end
    while (1) begin
      p = -1;
      for (int off = 0; off < N; off++)
        if (p < 0 && rem[(rr_m + off) % N] > 0) p = (rr_m + off) % N;
      if (p < 0) break;
      e.idx = p; e.x = px[p][k[p]]; e.y = py[p][k[p]]; e.sid = ps[p][k[p]]; e.tmo = first;
      exp_q.push_back(e);
      first = 1'b0;
      rem[p]--;
      k[p]++;
      rr_m = (p + 1) % N;
      n_exp++;
    end
    batch_id++;
  endtask

  task automatic wait_drain(input int bound);
    int c;
    c = 0;
    while (n_done != n_exp && c < bound) begin
      @(posedge clk);
      c++;
    end
    chk("drain", n_done, n_exp);
  endtask

  // Draw-unit model: accepts after 0..2 cycles, draws a few pixels, or hangs when stuck.
  initial begin
    int n;
    draw_done = 1'b1;
    pix_addr  = '0;
    forever begin
      @(negedge clk);
      if (draw_plot && !reset_n) begin
        if (stuck) begin
          @(posedge clk); #1 draw_done = 1'b0;
          while (stuck && !reset_n) @(posedge clk);
          #1 draw_done = 1'b1;
        end else begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          @(posedge clk); #1 draw_done = 1'b0;
          n = $urandom_range(3, 12);
          for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            if (reset_n) break;
            pix_addr = 10'($urandom_range(0, 1023));
          end
          if (!reset_n) begin
            @(posedge clk); #1;
          end
          draw_done = 1'b1;
        end
      end
    end
  end

  // Monitor + requester behaviour: pops expectations on draw_plot, checks done against the popped entry.
  initial begin
    exp_t cur;
    int   seen, plot_cyc, cyc;
    bit   inflight, en_p, dd_p, err_exp;
    seen = 0; plot_cyc = 0; cyc = 0; inflight = 0; en_p = 0; dd_p = 1; err_exp = 0;
    req = '0; x_pos_flat = '0; y_pos_flat = '0; sid_flat = '0;
    n_done = 0;
    for (int i = 0; i < N; i++) served[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_plot", draw_plot, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_x", draw_x, 0);
        chk("rst_y", draw_y, 0);
        chk("rst_sid", rom_addr[SW+9:10], 0);
        exp_q.delete();
        inflight = 0; err_exp = 0; req = '0; seen = batch_id;
        en_p = enable; dd_p = draw_done;
        continue;
      end
      if (draw_plot) begin
        chk("grant_enable", en_p, 1);
        chk("grant_draw_done", dd_p, 1);
        if (exp_q.size() == 0 || inflight) chk("spurious_plot", draw_plot, 0);
        else begin
          cur = exp_q.pop_front();
          chk("plot_x", draw_x, cur.x);
          chk("plot_y", draw_y, cur.y);
          chk("plot_sid", rom_addr[SW+9:10], cur.sid);
          inflight = 1; plot_cyc = cyc;
          x_pos_flat[10*cur.idx +: 10] = 10'($urandom_range(0, 1023));
          y_pos_flat[10*cur.idx +: 10] = 10'($urandom_range(0, 1023));
          sid_flat[SW*cur.idx +: SW]   = SW'($urandom_range(0, (1 << SW) - 1));
        end
      end else if (inflight) begin
        chk("hold_x", draw_x, cur.x);
        chk("hold_y", draw_y, cur.y);
        chk("rom_addr", rom_addr, cur.sid * 1024 + int'(pix_addr));
      end
      if (done != '0) begin
        if (!inflight) chk("spurious_done", done, 0);
        else begin
          chk("done_onehot", done, 1 << cur.idx);
          err_exp |= cur.tmo;
          chk("err", err, err_exp);
          if (cur.tmo) chk("timeout_cycles", cyc - plot_cyc, TMO + 1);
          inflight = 0;
          n_done++;
          served[cur.idx]++;
          if (served[cur.idx] < tot[cur.idx]) apply_pos(cur.idx, served[cur.idx]);
          else req[cur.idx] = 1'b0;
        end
      end
      if (batch_id != seen) begin
        seen = batch_id;
        for (int i = 0; i < N; i++) begin
          served[i] = 0;
          req[i] = (tot[i] > 0);
          if (tot[i] > 0) apply_pos(i, 0);
        end
      end
      en_p = enable;
      dd_p = draw_done;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    n_pass = 0; n_chk = 0; n_exp = 0; batch_id = 0; rr_m = 0; stuck = 0;
    enable = 1'b1;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;

    // single requester 2, sid 1 -> rom_addr 0x400 + pix_addr
    tot = '{0, 0, 1, 0};
    px[2][0] = 100; py[2][0] = 50; ps[2][0] = 1;
    run_batch(0);
    wait_drain(500);

    tot = '{2, 1, 1, 1};
    rand_pos(); run_batch(0); wait_drain(1000);
    tot = '{2, 2, 0, 0};
    rand_pos(); run_batch(0); wait_drain(1000);

    // enable low holds pending requests until it returns
    @(posedge clk); #1 enable = 1'b0;
    tot = '{1, 0, 1, 1};
    rand_pos(); run_batch(0);
    repeat (20) @(posedge clk);
    chk("enable_block", n_done, n_exp - 3);
    #1 enable = 1'b1;
    wait_drain(1000);

    for (int b = 0; b < 25; b++) begin
      rand_batch(); run_batch(0);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1 enable = 1'b0;
      repeat ($urandom_range(1, 15)) @(posedge clk);
      #1 enable = 1'b1;
      wait_drain(2000);
    end

    // reset in the middle of a draw
    tot = '{1, 1, 1, 1};
    rand_pos(); run_batch(0);
    c = 0;
    while (draw_done && c < 200) begin @(posedge clk); c++; end
    chk("draw_started", draw_done, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    rr_m = 0; n_exp = n_done;
    repeat (5) @(posedge clk);

    // hung draw unit: watchdog aborts, then draw_done low blocks the next grant
    stuck = 1'b1;
    tot = '{0, 1, 0, 1};
    rand_pos(); run_batch(1);
    c = 0;
    while (n_done < n_exp - 1 && c < 3000) begin @(posedge clk); c++; end
    chk("stuck_abort", n_done, n_exp - 1);
    repeat (10) @(posedge clk);
    chk("blocked_by_draw_done", n_done, n_exp - 1);
    stuck = 1'b0;
    wait_drain(500);

    // err stays set until reset
    rand_batch(); run_batch(0); wait_drain(1000);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    rr_m = 0; n_exp = n_done;
    rand_batch(); run_batch(0); wait_drain(1000);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
